// File: rtl/code_pulse_generator.sv
// Phase-coded transmit pulse generator: sends up to 32 BPSK chips, then opens a
// receive window for the remainder of the pulse period, and reports completion four-phase.
module code_pulse_generator (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic        GEN,
    input  logic [31:0] CODE,
    input  logic [15:0] CODE_LEN,
    input  logic [15:0] CODE_DURATION,
    input  logic [15:0] PULSE_LEN,
    input  logic [7:0]  PROBE_MODE,
    output logic        SIGNAL_GEN_OVER,
    output logic        TX_GATE,
    output logic        PHASE_SEL,
    output logic        RX_WIN,
    output logic        GEN_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CHIP  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] span_q, span_d;
    logic [31:0] period_q, period_d;
    logic [15:0] dur_q, dur_d;
    logic        tx_en_q, tx_en_d;
    logic        rx_en_q, rx_en_d;
    logic [31:0] chips_q, chips_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] chip_cnt_q, chip_cnt_d;

    logic        over_q, over_d;
    logic        tx_q, tx_d;
    logic        phase_q, phase_d;
    logic        rx_q, rx_d;
    logic        busy_q, busy_d;

    // Request decode, only consumed on the accepting edge
    logic [5:0]  len_clamp;
    logic [5:0]  align_shift;
    logic [31:0] span_in;
    logic [31:0] plen_ext;
    logic [31:0] period_in;
    logic        tx_en_in;
    logic        rx_en_in;

    assign len_clamp   = (CODE_LEN > 16'd32) ? 6'd32 : CODE_LEN[5:0];
    assign align_shift = 6'd32 - len_clamp;
    assign span_in     = {26'd0, len_clamp} * {16'd0, CODE_DURATION};
    assign plen_ext    = {16'd0, PULSE_LEN};
    assign period_in   = (plen_ext > span_in) ? plen_ext : span_in;
    assign tx_en_in    = (PROBE_MODE == 8'd1) || (PROBE_MODE == 8'd2) || (PROBE_MODE == 8'd4);
    assign rx_en_in    = (PROBE_MODE == 8'd1) || (PROBE_MODE == 8'd3) || (PROBE_MODE == 8'd4);

    logic chip_end;
    logic last_chip;
    logic gap_end;

    assign chip_end  = (chip_cnt_q == dur_q);
    assign last_chip = (cnt_q == span_q);
    assign gap_end   = (cnt_q == period_q);

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The SETUP cycle lets the latched span/period settle before chips start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (GEN) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!GEN) begin
                    state_d = S_IDLE;
                end else if (span_q != 32'd0) begin
                    state_d = S_CHIP;
                end else if (period_q != 32'd0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_CHIP: begin
                if (!GEN) begin
                    state_d = S_IDLE;
                end else if (last_chip) begin
                    state_d = (period_q > span_q) ? S_GAP : S_DONE;
                end
            end
            S_GAP: begin
                if (!GEN) begin
                    state_d = S_IDLE;
                end else if (gap_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!GEN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        span_d     = span_q;
        period_d   = period_q;
        dur_d      = dur_q;
        tx_en_d    = tx_en_q;
        rx_en_d    = rx_en_q;
        chips_d    = chips_q;
        cnt_d      = 32'd0;
        chip_cnt_d = 16'd0;

        if ((state_q == S_IDLE) && GEN) begin
            span_d   = span_in;
            period_d = period_in;
            dur_d    = CODE_DURATION;
            tx_en_d  = tx_en_in;
            rx_en_d  = rx_en_in;
            // First chip to send lands in bit 31
            chips_d  = CODE << align_shift;
        end

        case (state_d)
            S_CHIP: begin
                if (state_q == S_SETUP) begin
                    cnt_d      = 32'd1;
                    chip_cnt_d = 16'd1;
                end else begin
                    cnt_d      = cnt_q + 32'd1;
                    chip_cnt_d = chip_end ? 16'd1 : chip_cnt_q + 16'd1;
                    if (chip_end) begin
                        chips_d = {chips_q[30:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                cnt_d = (state_q == S_SETUP) ? 32'd1 : cnt_q + 32'd1;
            end
            default: begin
                cnt_d      = 32'd0;
                chip_cnt_d = 16'd0;
            end
        endcase

        over_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        tx_d    = (state_d == S_CHIP) && tx_en_q;
        rx_d    = (state_d == S_GAP) && rx_en_q;
        phase_d = 1'b0;
        if (state_d == S_CHIP) begin
            if (state_q == S_SETUP) begin
                phase_d = tx_en_q && chips_q[31];
            end else if (chip_end) begin
                phase_d = tx_en_q && chips_q[30];
            end else begin
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            span_q     <= 32'd0;
            period_q   <= 32'd0;
            dur_q      <= 16'd0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            chips_q    <= 32'd0;
            cnt_q      <= 32'd0;
            chip_cnt_q <= 16'd0;
            over_q     <= 1'b0;
            tx_q       <= 1'b0;
            phase_q    <= 1'b0;
            rx_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            span_q     <= span_d;
            period_q   <= period_d;
            dur_q      <= dur_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            chips_q    <= chips_d;
            cnt_q      <= cnt_d;
            chip_cnt_q <= chip_cnt_d;
            over_q     <= over_d;
            tx_q       <= tx_d;
            phase_q    <= phase_d;
            rx_q       <= rx_d;
            busy_q     <= busy_d;
        end
    end

    assign SIGNAL_GEN_OVER = over_q;
    assign TX_GATE         = tx_q;
    assign PHASE_SEL       = phase_q;
    assign RX_WIN          = rx_q;
    assign GEN_BUSY        = busy_q;

endmodule

// File: tb/tb_code_pulse_generator.sv
// Directed bench for code_pulse_generator: per-edge output checks of single pulses,
// abort/reset recovery, and an upstream-sequencer model running back-to-back requests.
module tb_code_pulse_generator;

    logic        CLOCK_10M;
    logic        RESET_N;
    logic        GEN;
    logic [31:0] CODE;
    logic [15:0] CODE_LEN;
    logic [15:0] CODE_DURATION;
    logic [15:0] PULSE_LEN;
    logic [7:0]  PROBE_MODE;
    logic        SIGNAL_GEN_OVER;
    logic        TX_GATE;
    logic        PHASE_SEL;
    logic        RX_WIN;
    logic        GEN_BUSY;

    int n_cmp;
    int n_bad;

    code_pulse_generator dut (
        .CLOCK_10M       (CLOCK_10M),
        .RESET_N         (RESET_N),
        .GEN             (GEN),
        .CODE            (CODE),
        .CODE_LEN        (CODE_LEN),
        .CODE_DURATION   (CODE_DURATION),
        .PULSE_LEN       (PULSE_LEN),
        .PROBE_MODE      (PROBE_MODE),
        .SIGNAL_GEN_OVER (SIGNAL_GEN_OVER),
        .TX_GATE         (TX_GATE),
        .PHASE_SEL       (PHASE_SEL),
        .RX_WIN          (RX_WIN),
        .GEN_BUSY        (GEN_BUSY)
    );

    initial CLOCK_10M = 1'b0;
    always #50 CLOCK_10M = ~CLOCK_10M;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_10M);
        #1;
    endtask

    // {GEN_BUSY, SIGNAL_GEN_OVER, RX_WIN, TX_GATE, PHASE_SEL}
    function automatic logic [31:0] obs();
        return {27'd0, GEN_BUSY, SIGNAL_GEN_OVER, RX_WIN, TX_GATE, PHASE_SEL};
    endfunction

    // span/per/tx_en/rx_en are hand-computed per vector; edge k expectations follow the timing rules
    task automatic run_pulse(input string name, input logic [31:0] code, input logic [15:0] len,
                             input logic [15:0] dur, input logic [15:0] plen, input logic [7:0] mode,
                             input int span, input int per, input bit tx_en, input bit rx_en,
                             input int abort_k, input int rst_k);
        int   lc;
        int   idx;
        logic e_tx, e_ph, e_rx, e_ov;
        lc = (len > 16'd32) ? 32 : int'(len);
        CODE = code; CODE_LEN = len; CODE_DURATION = dur; PULSE_LEN = plen; PROBE_MODE = mode;
        GEN = 1'b1;
        tick();
        check_eq($sformatf("%s e0", name), obs(), 32'h10);
        // Inputs after acceptance must not affect the pulse
        CODE = $urandom; CODE_LEN = 16'($urandom); CODE_DURATION = 16'($urandom_range(1, 7));
        PULSE_LEN = 16'($urandom); PROBE_MODE = 8'($urandom);
        for (int k = 1; k <= per + 3; k++) begin
            tick();
            e_tx = tx_en && (k <= span);
            e_ph = 1'b0;
            if (e_tx) begin
                idx  = lc - 1 - (k - 1) / int'(dur);
                e_ph = code[idx];
            end
            e_rx = rx_en && (k > span) && (k <= per);
            e_ov = (k > per);
            check_eq($sformatf("%s e%0d", name, k), obs(), {27'd0, 1'b1, e_ov, e_rx, e_tx, e_ph});
            if (k == abort_k) begin
                GEN = 1'b0;
                tick();
                check_eq($sformatf("%s abort e%0d", name, k + 1), obs(), 32'h0);
                for (int j = 2; j <= 4; j++) begin
                    tick();
                    check_eq($sformatf("%s abort e%0d", name, k + j), obs(), 32'h0);
                end
                $display("pulse %s: aborted at edge %0d", name, k);
                return;
            end
            if (k == rst_k) begin
                RESET_N = 1'b0;
                #5;
                check_eq($sformatf("%s async reset", name), obs(), 32'h0);
                GEN = 1'b0;
                #5;
                RESET_N = 1'b1;
                tick();
                check_eq($sformatf("%s after reset", name), obs(), 32'h0);
                $display("pulse %s: reset at edge %0d", name, k);
                return;
            end
        end
        GEN = 1'b0;
        tick();
        check_eq($sformatf("%s release", name), obs(), 32'h0);
        tick();
        check_eq($sformatf("%s idle", name), obs(), 32'h0);
        $display("pulse %s: code=%h len=%0d dur=%0d plen=%0d mode=%0d complete", name, code, len, dur, plen, mode);
    endtask

    task automatic run_back_to_back();
        logic [31:0] codes [8];
        logic [31:0] cap;
        int          ntx, nrx, nover;
        bit          seen, prev_over;
        codes[0] = 32'hDEAD_BEEF; codes[1] = 32'h0123_4567; codes[2] = 32'h8000_0001;
        codes[3] = 32'hFFFF_0000; codes[4] = 32'h5A5A_A5A5; codes[5] = 32'h0000_0000;
        codes[6] = 32'hFFFF_FFFF; codes[7] = 32'hC3A5_0F96;
        CODE_LEN = 16'd32; CODE_DURATION = 16'd1; PULSE_LEN = 16'd36; PROBE_MODE = 8'd1;
        for (int i = 0; i < 8; i++) begin
            CODE = codes[i];
            GEN  = 1'b1;
            cap = 32'd0; ntx = 0; nrx = 0; nover = 0; seen = 1'b0; prev_over = 1'b0;
            for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
                tick();
                if (cyc == 0) CODE = ~codes[i];
                if (TX_GATE) begin
                    cap = {cap[30:0], PHASE_SEL};
                    ntx++;
                end
                if (RX_WIN) nrx++;
                if (SIGNAL_GEN_OVER && !prev_over) nover++;
                prev_over = SIGNAL_GEN_OVER;
                if (SIGNAL_GEN_OVER) seen = 1'b1;
            end
            check_eq($sformatf("b2b%0d over seen", i), {31'd0, seen}, 32'd1);
            tick();
            check_eq($sformatf("b2b%0d over held", i), {31'd0, SIGNAL_GEN_OVER}, 32'd1);
            GEN = 1'b0;
            tick();
            check_eq($sformatf("b2b%0d release", i), obs(), 32'h0);
            tick();
            check_eq($sformatf("b2b%0d code", i), cap, codes[i]);
            check_eq($sformatf("b2b%0d tx chips", i), 32'(ntx), 32'd32);
            check_eq($sformatf("b2b%0d rx cycles", i), 32'(nrx), 32'd4);
            check_eq($sformatf("b2b%0d over count", i), 32'(nover), 32'd1);
            $display("b2b pulse %0d: sent %h captured %h", i, codes[i], cap);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RESET_N = 1'b0; GEN = 1'b0;
        CODE = 32'd0; CODE_LEN = 16'd0; CODE_DURATION = 16'd0; PULSE_LEN = 16'd0; PROBE_MODE = 8'd0;
        #120;
        check_eq("reset outputs", obs(), 32'h0);
        RESET_N = 1'b1;
        tick();
        check_eq("post reset idle", obs(), 32'h0);

        //        name        code          len    dur    plen   mode  span per tx rx abort rst
        run_pulse("basic",    32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd1, 12, 20, 1, 1, 0, 0);
        run_pulse("short_pl", 32'h0000_000B, 16'd4,  16'd3, 16'd5,  8'd1, 12, 12, 1, 0, 0, 0);
        run_pulse("zero",     32'h0000_A5A5, 16'd0,  16'd3, 16'd0,  8'd1, 0,  0,  1, 1, 0, 0);
        run_pulse("gap_only", 32'h0000_A5A5, 16'd0,  16'd3, 16'd6,  8'd1, 0,  6,  1, 1, 0, 0);
        run_pulse("clamp",    32'hC3A5_0F96, 16'd40, 16'd1, 16'd10, 8'd1, 32, 32, 1, 1, 0, 0);
        run_pulse("rx_only",  32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd3, 12, 20, 0, 1, 0, 0);
        run_pulse("tx_only",  32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd2, 12, 20, 1, 0, 0, 0);
        run_pulse("loopback", 32'h0000_0036, 16'd6,  16'd2, 16'd15, 8'd4, 12, 15, 1, 1, 0, 0);
        run_pulse("bad_mode", 32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd9, 12, 20, 0, 0, 0, 0);
        run_pulse("abort",    32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd1, 12, 20, 1, 1, 5, 0);
        tick();
        run_pulse("reset",    32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd1, 12, 20, 1, 1, 0, 7);
        tick();
        run_pulse("recover",  32'h0000_000B, 16'd4,  16'd3, 16'd20, 8'd1, 12, 20, 1, 1, 0, 0);

        run_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
